// File: rtl/gray_counter_pkg.sv
// Shared constants and binary/Gray conversion helpers for the Gray-code counter.
// Helpers operate on MAX_WIDTH bits; callers zero-extend narrower values and truncate results.
package gray_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;
    localparam int unsigned MAX_WIDTH     = 16;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] value);
        return value ^ (value >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrow results intact.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] value);
        logic [MAX_WIDTH-1:0] bin;
        bin[MAX_WIDTH-1] = value[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ value[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Simulation-only monitor: gray must step by exactly one bit and must encode the binary count.
// Instantiated by gray_counter_core only when GRAY_COUNTER_STEP_CHECK_EN is defined.
module gray_step_checker
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] count,
    input logic [WIDTH-1:0] gray
);

    logic             seen_rst;
    logic             seen_rst_q;
    logic             rst_q;
    logic [WIDTH-1:0] gray_q;

    // Values sampled at an edge are the result of the previous edge; history lags by one more.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seen_rst <= 1'b1;
        end
        seen_rst_q <= seen_rst;
        rst_q      <= rst;
        gray_q     <= gray;

        if (seen_rst) begin
            assert (count == WIDTH'(gray2bin(MAX_WIDTH'(gray))))
            else $error("gray_step_checker: gray %0h does not encode count %0h", gray, count);
        end
        if (seen_rst_q && rst_q) begin
            assert ($countones(gray ^ gray_q) == 1)
            else $error("gray_step_checker: gray stepped %0h -> %0h", gray_q, gray);
        end
    end

endmodule

// File: rtl/gray_counter_core.sv
// Free-running binary counter with a registered Gray-code copy updated on the same edge.
// Define GRAY_COUNTER_STEP_CHECK_EN to compile in the gray_step_checker monitor.
module gray_counter_core
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] o_o,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] gray_next;

    // Gray is encoded from the next count so both registers load together, glitch-free.
    always_comb begin
        count_next = o_o + WIDTH'(1);
        gray_next  = WIDTH'(bin2gray(MAX_WIDTH'(count_next)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_o  <= '0;
            gray <= '0;
        end else begin
            o_o  <= count_next;
            gray <= gray_next;
        end
    end

`ifdef GRAY_COUNTER_STEP_CHECK_EN
    gray_step_checker #(
        .WIDTH (WIDTH)
    ) u_step_checker (
        .clk   (clk),
        .rst   (rst),
        .count (o_o),
        .gray  (gray)
    );
`else
    // No monitor in the default build; port behaviour is unchanged.
`endif

endmodule

// File: tb/tb_gray_counter_core.sv
// Directed scoreboard bench for gray_counter_core at WIDTH=3 and WIDTH=4 sharing clk/rst.
module tb_gray_counter_core;
    import gray_counter_pkg::*;

    typedef struct packed {
        logic [2:0] count3;
        logic [2:0] gray3;
        logic [3:0] count4;
        logic [3:0] gray4;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] o_o3;
    logic [2:0] gray3;
    logic [3:0] o_o4;
    logic [3:0] gray4;

    int unsigned checks;
    int unsigned passed;
    int unsigned failed;

    exp_t       sb_q[$];
    logic [2:0] model3;
    logic [3:0] model4;
    logic [2:0] prev_gray3;
    logic [3:0] prev_gray4;
    logic       prev_known;

    logic [2:0] gseq [8];

    gray_counter_core #(.WIDTH(3)) u_dut3 (
        .clk  (clk),
        .rst  (rst),
        .o_o  (o_o3),
        .gray (gray3)
    );

    gray_counter_core #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .o_o  (o_o4),
        .gray (gray4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive rst, push the model's expectation, clock once, then pop and compare.
    task automatic step(input logic r, input string tag);
        exp_t e;
        rst    = r;
        model3 = r ? model3 + 3'd1 : 3'd0;
        model4 = r ? model4 + 4'd1 : 4'd0;
        e.count3 = model3;
        e.gray3  = model3 ^ (model3 >> 1);
        e.count4 = model4;
        e.gray4  = model4 ^ (model4 >> 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " count3"}, 16'(o_o3), 16'(e.count3));
            check({tag, " gray3"}, 16'(gray3), 16'(e.gray3));
            check({tag, " count4"}, 16'(o_o4), 16'(e.count4));
            check({tag, " gray4"}, 16'(gray4), 16'(e.gray4));
        end
        if (r && prev_known) begin
            check({tag, " onebit3"}, 16'($countones(prev_gray3 ^ gray3)), 16'd1);
            check({tag, " onebit4"}, 16'($countones(prev_gray4 ^ gray4)), 16'd1);
            check({tag, " g2b3"}, gray2bin(16'(gray3)), 16'(o_o3));
            check({tag, " g2b4"}, gray2bin(16'(gray4)), 16'(o_o4));
        end
        prev_gray3 = gray3;
        prev_gray4 = gray4;
        prev_known = 1'b1;
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        failed     = 0;
        model3     = 3'd0;
        model4     = 4'd0;
        prev_gray3 = 3'd0;
        prev_gray4 = 4'd0;
        prev_known = 1'b0;
        rst        = 1'b0;
        gseq[0] = 3'b001; gseq[1] = 3'b011; gseq[2] = 3'b010; gseq[3] = 3'b110;
        gseq[4] = 3'b111; gseq[5] = 3'b101; gseq[6] = 3'b100; gseq[7] = 3'b000;

        // Reset held for two edges
        for (int i = 0; i < 2; i++) begin
            step(1'b0, "reset_hold");
            check("reset_hold o_o", 16'(o_o3), 16'd0);
            check("reset_hold gray", 16'(gray3), 16'd0);
        end

        // One full period against the literal Gray sequence
        for (int i = 0; i < 8; i++) begin
            step(1'b1, "full_seq");
            check("full_seq literal_gray", 16'(gray3), 16'(gseq[i]));
            check("full_seq literal_count", 16'(o_o3), 16'((i + 1) % 8));
        end

        // Mid-count reset at count 101
        for (int i = 0; i < 5; i++) step(1'b1, "to_mid");
        check("mid count", 16'(o_o3), 16'h5);
        check("mid gray", 16'(gray3), 16'h7);
        step(1'b0, "mid_reset");
        check("mid_reset count", 16'(o_o3), 16'h0);
        check("mid_reset gray", 16'(gray3), 16'h0);
        step(1'b1, "after_mid");
        check("after_mid count", 16'(o_o3), 16'h1);
        check("after_mid gray", 16'(gray3), 16'h1);

        // Three full periods of single-bit steps
        for (int i = 0; i < 24; i++) step(1'b1, "periods");

        // WIDTH=4 wrap from 1111
        step(1'b0, "w4_reset");
        for (int i = 0; i < 15; i++) step(1'b1, "w4_run");
        check("w4 top count", 16'(o_o4), 16'hF);
        check("w4 top gray", 16'(gray4), 16'h8);
        step(1'b1, "w4_wrap");
        check("w4 wrap count", 16'(o_o4), 16'h0);
        check("w4 wrap gray", 16'(gray4), 16'h0);

        check("scoreboard drained", 16'(sb_q.size()), 16'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gray_counter_core.md
GRAY_COUNTER_CORE -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled only on the rising clk edge.
REQ-004 o_o  output  WIDTH  registered binary count value.
REQ-005 gray  output  WIDTH  registered Gray-code encoding of o_o.
REQ-006 The interface SHALL have no other ports.

Function
REQ-007 When rst=1 at a rising clk edge, o_o SHALL become (o_o+1) mod 2^WIDTH.
REQ-008 Gray encoding SHALL be gray = o_o XOR (o_o >> 1), bitwise over WIDTH bits.
REQ-009 gray SHALL be a register loaded with the encoding of the next o_o value, so that o_o and gray update on the same edge with zero relative latency and no combinational glitches.
REQ-010 At all times after the first clock edge, gray SHALL equal the encoding of the current o_o.
REQ-011 Wrap-around: from o_o = 2^WIDTH-1 (gray = 1 followed by zeros), the next edge SHALL give o_o=0 and gray=0, a single-bit Gray change.
REQ-012 Every non-reset edge SHALL change exactly one bit of gray, including at wrap.
REQ-013 Count period SHALL be 2^WIDTH cycles; WIDTH=3 gray sequence: 000,001,011,010,110,111,101,100, repeat.
REQ-014 No enable, load or direction control; the counter advances on every edge where rst=1.

Reset
REQ-015 When rst=0 at a rising clk edge, o_o and gray SHALL both become 0 on that edge; reset has priority over counting.
REQ-016 Reset mid-count SHALL take effect on the next edge regardless of current value; no partial state retained.
REQ-017 While rst is held 0, both outputs SHALL remain 0.
REQ-018 On the first edge with rst=1 after reset, o_o SHALL become 1 and gray SHALL become 001 (WIDTH=3).
REQ-019 Before the first clock edge, output values are undefined; no asynchronous path from rst.

Configuration
REQ-020 Macro GRAY_COUNTER_STEP_CHECK_EN, when defined, SHALL compile in a simulation checker.
- The checker SHALL raise $error if, on any non-reset edge, gray changes in other than exactly one bit.
- The checker SHALL raise $error if gray differs from the encoding of o_o.
REQ-021 Without GRAY_COUNTER_STEP_CHECK_EN, no checker logic SHALL be present; port behaviour SHALL be identical either way.

Structure
REQ-022 Package gray_counter_pkg SHALL hold:
- the default width constant (3);
- pure functions bin2gray(value) and gray2bin(value), both WIDTH-generic.
REQ-023 The RTL SHALL use bin2gray for REQ-008; gray2bin SHALL be used only by the checker and the bench.
REQ-024 One sub-module, gray_step_checker, instantiated only under GRAY_COUNTER_STEP_CHECK_EN, SHALL implement REQ-020.

Verification
REQ-025 Reset: rst=0 for 2 edges -> o_o=000, gray=000 after each edge.
REQ-026 Full sequence (WIDTH=3): release rst, run 8 edges -> o_o 001..111 then 000; gray 001,011,010,110,111,101,100,000.
REQ-027 Mid-count reset: at o_o=101 (gray=111), drive rst=0 for one edge -> 000/000; next edge -> 001/001.
REQ-028 Single-bit property: over 3 full periods, popcount(gray_prev XOR gray) = 1 on every non-reset edge, and gray2bin(gray) = o_o.
REQ-029 WIDTH=4: from o_o=1111 (gray=1000), one edge -> o_o=0000, gray=0000.
REQ-030 Checker build: with GRAY_COUNTER_STEP_CHECK_EN defined, a clean run of REQ-026 reports zero errors.
